// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and lane slicing helper for piso_shift_multi
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int MAX_DATA_W = 1024;
  // Word for lane c out of a packed CHANNELS*w bus, zero-extended to MAX_DATA_W.
  function automatic logic [MAX_DATA_W-1:0] lane_slice(input logic [MAX_DATA_W-1:0] data, input int c, input int w);
    return (data >> (c * w)) & ((MAX_DATA_W'(1) << w) - MAX_DATA_W'(1));
  endfunction
endpackage

// File: rtl/piso_lane.sv
// piso_lane: one WIDTH-bit shift register with parallel load and head output
//   clk/rst_n: clock, async active-low reset
//   i_load: capture i_data; i_shift: move one bit toward the head, zero-filling the tail
//   o_head: MSB when MSB_FIRST else LSB
module piso_lane #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_head
);
  logic [WIDTH-1:0] r_sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sr <= '0;
    else if (i_load) r_sr <= i_data;
    else if (i_shift) r_sr <= MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
  assign o_head = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
endmodule

// File: rtl/piso_shift_multi.sv
// piso_shift_multi: multi-lane parallel-in/serial-out shifter with Busy/Done handshake
//   CLK/Reset_n: clock, async active-low reset
//   Load/Data: capture request and CHANNELS*WIDTH parallel words
//   Shift_En: advance one bit while Busy
//   Serial_Out: head bit per lane; Busy: word in progress; Done: pulse after last bit
//   Bit_Cnt: index of the bit currently on Serial_Out
module piso_shift_multi
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic                      CLK,
  input  logic                      Reset_n,
  input  logic                      Load,
  input  logic [CHANNELS*WIDTH-1:0] Data,
  input  logic                      Shift_En,
  output logic [CHANNELS-1:0]       Serial_Out,
  output logic                      Busy,
  output logic                      Done,
  output logic [CNT_W-1:0]          Bit_Cnt
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_last, w_load, w_shift;
  assign w_last  = r_state == SHIFT && Shift_En && r_cnt == CNT_W'(WIDTH - 1);
  // Loads are accepted only when idle or on the final-bit edge; any other Load is dropped.
  assign w_load  = Load && (r_state == IDLE || w_last);
  assign w_shift = r_state == SHIFT && Shift_En && !w_load;
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = w_load ? SHIFT : w_last ? IDLE : r_state;
  always_comb Busy = r_state == SHIFT;
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= (w_load || w_last) ? '0 : w_shift ? r_cnt + 1'b1 : r_cnt;
      r_done <= w_last;
    end
  assign Done    = r_done;
  assign Bit_Cnt = r_cnt;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    piso_lane #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane (
      .clk    (CLK),
      .rst_n  (Reset_n),
      .i_load (w_load),
      .i_shift(w_shift),
      .i_data (WIDTH'(lane_slice(MAX_DATA_W'(Data), c, WIDTH))),
      .o_head (Serial_Out[c])
    );
  end
endmodule

// File: tb/tb_piso_shift_multi.sv
// tb_piso_shift_multi: vector table, corner sequences and random run against a bit-index model
module tb_piso_shift_multi;
  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Load = 1'b0;
  logic        Shift_En = 1'b0;
  logic [63:0] Data = '0;
  logic [1:0]  so_a, so_b;
  logic [3:0]  so_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [2:0]  cnt_a, cnt_b;
  logic [3:0]  cnt_c;
  int n_pass = 0, n_tot = 0;
  always #5 CLK = ~CLK;

  piso_shift_multi u_a (.CLK(CLK), .Reset_n(Reset_n), .Load(Load), .Data(Data[15:0]), .Shift_En(Shift_En),
                        .Serial_Out(so_a), .Busy(busy_a), .Done(done_a), .Bit_Cnt(cnt_a));
  piso_shift_multi #(.MSB_FIRST(1'b0)) u_b (.CLK(CLK), .Reset_n(Reset_n), .Load(Load), .Data(Data[15:0]),
                        .Shift_En(Shift_En), .Serial_Out(so_b), .Busy(busy_b), .Done(done_b), .Bit_Cnt(cnt_b));
  piso_shift_multi #(.WIDTH(16), .CHANNELS(4)) u_c (.CLK(CLK), .Reset_n(Reset_n), .Load(Load), .Data(Data),
                        .Shift_En(Shift_En), .Serial_Out(so_c), .Busy(busy_c), .Done(done_c), .Bit_Cnt(cnt_c));

  logic [3:0] a_so[3], a_cnt[3];
  logic       a_busy[3], a_done[3];
  assign a_so[0] = {2'b0, so_a};
  assign a_so[1] = {2'b0, so_b};
  assign a_so[2] = so_c;
  assign a_cnt[0] = {1'b0, cnt_a};
  assign a_cnt[1] = {1'b0, cnt_b};
  assign a_cnt[2] = cnt_c;
  assign a_busy[0] = busy_a;
  assign a_busy[1] = busy_b;
  assign a_busy[2] = busy_c;
  assign a_done[0] = done_a;
  assign a_done[1] = done_b;
  assign a_done[2] = done_c;

  // Model: each build holds its captured words and the index of the bit on display (-1 = idle).
  int         m_pos[3];
  logic [15:0] m_w[3][4];
  bit         m_done[3];
  function automatic int pw(int d); return d == 2 ? 16 : 8; endfunction
  function automatic int pc(int d); return d == 2 ? 4 : 2; endfunction
  function automatic bit pm(int d); return d != 1; endfunction

  function automatic logic mbit(int d, int c);
    if (m_pos[d] < 0) return 1'b0;
    return m_w[d][c][pm(d) ? pw(d) - 1 - m_pos[d] : m_pos[d]];
  endfunction

  task automatic mreset();
    for (int d = 0; d < 3; d++) begin
      m_pos[d] = -1;
      m_done[d] = 1'b0;
    end
  endtask

  task automatic mcap(int d);
    m_pos[d] = 0;
    for (int c = 0; c < pc(d); c++) m_w[d][c] = 16'((Data >> (c * pw(d))) & ((64'd1 << pw(d)) - 64'd1));
  endtask

  task automatic mstep(int d);
    m_done[d] = 1'b0;
    if (m_pos[d] < 0) begin
      if (Load) mcap(d);
    end else if (Shift_En) begin
      if (m_pos[d] == pw(d) - 1) begin
        m_done[d] = 1'b1;
        if (Load) mcap(d);
        else m_pos[d] = -1;
      end else m_pos[d]++;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic mcheck(int d);
    logic [3:0] e;
    e = '0;
    for (int c = 0; c < pc(d); c++) e[c] = mbit(d, c);
    chk($sformatf("m%0d_so", d), 32'(a_so[d]), 32'(e));
    chk($sformatf("m%0d_busy", d), 32'(a_busy[d]), 32'(m_pos[d] >= 0));
    chk($sformatf("m%0d_done", d), 32'(a_done[d]), 32'(m_done[d]));
    chk($sformatf("m%0d_cnt", d), 32'(a_cnt[d]), m_pos[d] < 0 ? 32'd0 : 32'(m_pos[d]));
  endtask

  task automatic tick(logic ld, logic sh, logic [63:0] dt);
    Load = ld;
    Shift_En = sh;
    Data = dt;
    @(posedge CLK);
    #1;
    for (int d = 0; d < 3; d++) begin
      mstep(d);
      mcheck(d);
    end
  endtask

  typedef struct {
    logic ld, sh;
    logic [15:0] dt;
    logic [1:0] so;
    logic bs, dn;
    logic [2:0] cn;
    int sob;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(logic ld, logic sh, logic [15:0] dt, logic [1:0] so, logic bs, logic dn,
                             logic [2:0] cn, int sob = -1);
    vec_t r;
    r.ld = ld; r.sh = sh; r.dt = dt; r.so = so; r.bs = bs; r.dn = dn; r.cn = cn; r.sob = sob;
    return r;
  endfunction

  initial begin
    mreset();
    #2;
    chk("rst_so", 32'(so_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);
    for (int d = 0; d < 3; d++) mcheck(d);
    @(negedge CLK);
    Reset_n = 1'b1;
    // lane0=5, lane1=15, MSB first, continuous shift
    tv.push_back(v(1, 0, 16'h0F05, 0, 1, 0, 0));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 1));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 2));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 3));
    tv.push_back(v(0, 1, 16'hFFFF, 2, 1, 0, 4));
    tv.push_back(v(0, 1, 16'hFFFF, 3, 1, 0, 5));
    tv.push_back(v(0, 1, 16'hFFFF, 2, 1, 0, 6));
    tv.push_back(v(0, 1, 16'hFFFF, 3, 1, 0, 7));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 0, 1, 0));
    tv.push_back(v(0, 1, 16'h0000, 0, 0, 0, 0));
    // 0x81 with stalls
    tv.push_back(v(1, 0, 16'h0081, 1, 1, 0, 0));
    tv.push_back(v(0, 0, 16'hFFFF, 1, 1, 0, 0));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 1));
    tv.push_back(v(0, 0, 16'hFFFF, 0, 1, 0, 1));
    tv.push_back(v(0, 0, 16'hFFFF, 0, 1, 0, 1));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 2));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 3));
    tv.push_back(v(0, 0, 16'hFFFF, 0, 1, 0, 3));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 4));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 5));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 6));
    tv.push_back(v(0, 1, 16'hFFFF, 1, 1, 0, 7));
    tv.push_back(v(0, 0, 16'hFFFF, 1, 1, 0, 7));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 0, 1, 0));
    // back-to-back: reload 0xFF on the final-bit edge
    tv.push_back(v(1, 0, 16'h0005, 0, 1, 0, 0));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 1));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 2));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 3));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 4));
    tv.push_back(v(0, 1, 16'hFFFF, 1, 1, 0, 5));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 6));
    tv.push_back(v(0, 1, 16'hFFFF, 1, 1, 0, 7));
    tv.push_back(v(1, 1, 16'h00FF, 1, 1, 1, 0));
    tv.push_back(v(0, 1, 16'h0000, 1, 1, 0, 1));
    for (int k = 2; k < 8; k++) tv.push_back(v(0, 1, 16'hFFFF, 1, 1, 0, 3'(k)));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 0, 1, 0));
    // Load with Shift_En from idle, then an ignored mid-word Load at Bit_Cnt=3
    tv.push_back(v(1, 1, 16'h00A5, 1, 1, 0, 0, 1));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 1, 0));
    tv.push_back(v(0, 1, 16'hFFFF, 1, 1, 0, 2, 1));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 3, 0));
    tv.push_back(v(1, 1, 16'h003C, 0, 1, 0, 4, 0));
    tv.push_back(v(0, 1, 16'hFFFF, 1, 1, 0, 5, 1));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 1, 0, 6, 0));
    tv.push_back(v(0, 1, 16'hFFFF, 1, 1, 0, 7, 1));
    tv.push_back(v(0, 1, 16'hFFFF, 0, 0, 1, 0, 0));
    foreach (tv[i]) begin
      tick(tv[i].ld, tv[i].sh, {48'h0, tv[i].dt});
      chk($sformatf("v%0d_so", i), 32'(so_a), 32'(tv[i].so));
      chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(tv[i].bs));
      chk($sformatf("v%0d_done", i), 32'(done_a), 32'(tv[i].dn));
      chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(tv[i].cn));
      if (tv[i].sob >= 0) chk($sformatf("v%0d_lsb_so", i), 32'(so_b), tv[i].sob);
    end
    // asynchronous reset mid-word at Bit_Cnt=4, clear of any clock edge
    for (int k = 0; k < 17; k++) tick(1'b0, 1'b1, 64'h0);
    tick(1'b1, 1'b0, 64'h1234_5678_9ABC_0081);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 64'h0);
    chk("pre_rst_cnt", 32'(cnt_a), 4);
    #2 Reset_n = 1'b0;
    #1;
    mreset();
    chk("arst_so", 32'(so_a), 0);
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_cnt", 32'(cnt_a), 0);
    chk("arst_done", 32'(done_a), 0);
    for (int d = 0; d < 3; d++) mcheck(d);
    #2 Reset_n = 1'b1;
    tick(1'b0, 1'b1, 64'h0);
    tick(1'b1, 1'b0, {$urandom, $urandom});
    for (int k = 0; k < 17; k++) tick(1'b0, 1'b1, {$urandom, $urandom});
    for (int k = 0; k < 600; k++)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, {$urandom, $urandom});
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/piso_shift_multi.md
Name: piso_shift_multi

Overview:
Parametrised parallel-in/serial-out shifter, the successor to the fixed 8-bit two-channel load/shift block. It captures CHANNELS words of WIDTH bits on Load and shifts all channels out in lockstep, one bit per enabled clock. Bit order is selectable. Busy/Done handshaking lets an upstream controller stream words back to back. It sits between parallel data sources (counters, registers) and serial consumers (LED/display drivers, serial links).

Parameters:
WIDTH, 8, bits per channel word (>=2)
CHANNELS, 2, number of parallel serial lanes (>=1)
MSB_FIRST, 1, 1 = shift out MSB first, 0 = LSB first
CNT_W, $clog2(WIDTH), width of Bit_Cnt (derived, not overridden)

Ports:
CLK  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Load  in  1  capture request; sampled on the rising edge
Data  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
Shift_En  in  1  advance one bit when Busy
Serial_Out  out  CHANNELS  current bit of each lane; bit c = lane c
Busy  out  1  word in progress
Done  out  1  one-cycle pulse after final bit consumed
Bit_Cnt  out  CNT_W  index of the bit currently on Serial_Out

Behaviour:
- Reset (asynchronous, Reset_n=0): state=IDLE; shift regs=0; Serial_Out=0; Busy=0; Done=0; Bit_Cnt=0. Reset mid-word aborts with no Done pulse.
- FSM states:
  - IDLE: Busy=0. When Load=1 at an edge, capture Data into per-lane shift regs, Bit_Cnt<=0, go to SHIFT.
  - SHIFT: Busy=1.
- Serial_Out is driven from the register head: MSB when MSB_FIRST=1, LSB otherwise. The first bit is visible on the clock after the capture edge (latency 1).
- In SHIFT, Shift_En=1 at an edge shifts each lane by one toward the head, zero-filling the tail, and increments Bit_Cnt. Shift_En=0 holds all state; stalls of any length are legal.
- Final bit: an edge in SHIFT with Shift_En=1 and Bit_Cnt==WIDTH-1 causes Done<=1 for exactly one cycle and Bit_Cnt<=0.
  - If Load=0: go to IDLE; Busy<=0; Serial_Out shows 0.
  - If Load=1 on that same edge: reload Data and stay in SHIFT. Busy remains 1 and Done still pulses. There is no gap bit between words.
- Load in SHIFT other than on the final-bit edge is ignored. The word in flight is not disturbed and the new data is lost. This is required behaviour.
- Load and Shift_En in IDLE: Load wins, and Shift_En is ignored on the capture edge.
- Lanes are always synchronous. Every lane shifts on every enabled edge, and all lanes share one Bit_Cnt.
- Data is sampled only on capture edges. Changes at other times have no effect.

Decomposition:
- Shared package piso_pkg:
  - state enum (IDLE, SHIFT)
  - function lane_slice(data, c) returning the WIDTH-bit word for lane c
- One natural sub-module: piso_lane. It is a single WIDTH-bit shift register with load, shift and head output, parameterised by MSB_FIRST, and is instantiated CHANNELS times by generate.
- FSM, Bit_Cnt, Busy and Done live in the top module.

Test Plan:
- Defaults (W=8, C=2), MSB first, lane0=5, lane1=15, Load one cycle, then Shift_En=1 continuously.
  - Lane0 shows 0,0,0,0,0,1,0,1 and lane1 shows 0,0,0,0,1,1,1,1 on the 8 cycles after capture.
  - Done pulses the cycle after the 8th shift; Busy falls with it.
- MSB_FIRST=0, lane0=8'hA5, continuous Shift_En.
  - Lane0 shows 1,0,1,0,0,1,0,1.
  - Bit_Cnt steps 0..7 and then returns to 0.
- Shift_En toggled 1,0,0,1,... with data 8'h81.
  - Serial_Out and Bit_Cnt hold during the 0 cycles.
  - Done arrives only after 8 enabled edges.
- Back-to-back streaming: Load=1 on the final-bit edge with new lane0=8'hFF.
  - Busy stays 1 and Done pulses once.
  - The next cycle shows 1 with no idle gap.
- Load=1 mid-word (Bit_Cnt=3) with different Data.
  - Output sequence is unchanged.
  - Done occurs at the original time.
- Reset_n pulsed low for 3 ns mid-word at Bit_Cnt=4 (asynchronous, not aligned to CLK).
  - Outputs go to 0, Busy=0, Bit_Cnt=0 immediately, with no Done.
  - After release, a fresh Load of W=16, C=4 (second build) shifts all four lanes correctly.
